// File: rtl/cpu_bus_lockstep_checker.sv
// cpu_bus_lockstep_checker
//
// Compares the bus-cycle stream of a 6502 core under verification (DUV) with
// the stream of a reference core. Both cores share one clock and one reset.
// Each stream is buffered in its own FIFO, so the two cores may drift apart
// by up to DEPTH bus cycles. Whenever both FIFO heads hold an entry, the two
// heads are compared ({addr, data, rw}) and popped together.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              capture enable; when it falls, the checker drains
//                       the FIFOs and then returns to idle
//   duv_* / ref_*       bus cycles from the DUV and the reference core
//                       (valid, addr, data, rw)
//   match_count         number of compared pairs that matched (wraps)
//   mism_count          number of compared pairs that differed (saturates)
//   mismatch            sticky: at least one mismatch was seen
//   overflow            sticky: a push was attempted into a full FIFO
//   orphan              sticky: drain ended with only one side non-empty
//   fail                checker is in the FAIL state
//   mism_index          0-based pair number of the first mismatch
//   mism_duv, mism_ref  {addr, data, rw} of both sides at the first mismatch

module cpu_bus_lockstep_checker #(
  parameter int DEPTH            = 8,
  parameter int ADDR_W           = 16,
  parameter int DATA_W           = 8,
  parameter bit STOP_ON_MISMATCH = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     duv_valid,
  input  logic [ADDR_W-1:0]        duv_addr,
  input  logic [DATA_W-1:0]        duv_data,
  input  logic                     duv_rw,
  input  logic                     ref_valid,
  input  logic [ADDR_W-1:0]        ref_addr,
  input  logic [DATA_W-1:0]        ref_data,
  input  logic                     ref_rw,
  output logic [31:0]              match_count,
  output logic [15:0]              mism_count,
  output logic                     mismatch,
  output logic                     overflow,
  output logic                     orphan,
  output logic                     fail,
  output logic [31:0]              mism_index,
  output logic [ADDR_W+DATA_W:0]   mism_duv,
  output logic [ADDR_W+DATA_W:0]   mism_ref
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W + 1;
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FAIL
  } state_t;

  state_t state_q, state_d;

  // Index 0 is the DUV side, index 1 is the reference side.
  logic [1:0]         in_valid;
  logic [1:0][EW-1:0] in_entry;
  logic [1:0]         fifo_empty;
  logic [1:0]         fifo_full;
  logic [1:0]         push_req;
  logic [1:0]         push_ok;
  logic [1:0][EW-1:0] head;
  logic               pop;
  logic               flush;
  logic               ovf_now;
  logic               pair_eq;
  logic               match_now;
  logic               mism_now;

  assign in_valid    = {ref_valid, duv_valid};
  assign in_entry[0] = {duv_addr, duv_data, duv_rw};
  assign in_entry[1] = {ref_addr, ref_data, ref_rw};

  // Per-side FIFO. Pointers carry one extra wrap bit so that full and empty
  // can be told apart when the index bits are equal. The head is read
  // combinationally so that an entry pushed at the end of one clk can be
  // compared in the very next clk.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [AW:0]   wr_ptr_q, wr_ptr_d;
      logic [AW:0]   rd_ptr_q, rd_ptr_d;
      logic [EW-1:0] mem_q [DEPTH];

      assign fifo_empty[gi] = (wr_ptr_q == rd_ptr_q);
      assign fifo_full[gi]  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      assign head[gi]       = mem_q[rd_ptr_q[AW-1:0]];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
          // No pushes happen while draining, so catching the read pointer
          // up to the write pointer empties this side.
          rd_ptr_d = wr_ptr_q;
        end else begin
          if (push_ok[gi]) wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (pop)         rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      // Storage needs no reset: it is only read once the pointers say so.
      always_ff @(posedge clk) begin
        if (push_ok[gi]) mem_q[wr_ptr_q[AW-1:0]] <= in_entry[gi];
      end
    end
  endgenerate

  // Compare/pop whenever both heads are present while running or draining.
  assign pop       = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                     !fifo_empty[0] && !fifo_empty[1];
  assign push_req  = (state_q == S_RUN) ? in_valid : 2'b00;
  // A full FIFO may still accept a push when its head is popped in the same clk.
  assign push_ok   = push_req & (~fifo_full | {2{pop}});
  assign ovf_now   = |(push_req & fifo_full & ~{2{pop}});
  assign flush     = (state_q == S_DRAIN) && (fifo_empty[0] ^ fifo_empty[1]);
  assign pair_eq   = (head[0] == head[1]);
  assign match_now = pop && pair_eq;
  assign mism_now  = pop && !pair_eq;

  // State machine
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (ovf_now || (STOP_ON_MISMATCH && mism_now)) state_d = S_FAIL;
        else if (!enable)                               state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (STOP_ON_MISMATCH && mism_now)            state_d = S_FAIL;
        else if (&fifo_empty || flush)               state_d = S_IDLE;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Status counters and first-mismatch snapshot
  logic [31:0]   match_q, match_d;
  logic [15:0]   mism_q, mism_d;
  logic          mismatch_q, mismatch_d;
  logic          overflow_q, overflow_d;
  logic          orphan_q, orphan_d;
  logic [31:0]   index_q, index_d;
  logic [EW-1:0] snap_duv_q, snap_duv_d;
  logic [EW-1:0] snap_ref_q, snap_ref_d;

  always_comb begin
    match_d    = match_q;
    mism_d     = mism_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;
    orphan_d   = orphan_q;
    index_d    = index_q;
    snap_duv_d = snap_duv_q;
    snap_ref_d = snap_ref_q;

    if (match_now) match_d = match_q + 32'd1;

    if (mism_now) begin
      if (mism_q != 16'hFFFF) mism_d = mism_q + 16'd1;
      mismatch_d = 1'b1;
      // Only the first divergence is kept; later ones leave the snapshot alone.
      if (!mismatch_q) begin
        index_d    = match_q + {16'd0, mism_q};
        snap_duv_d = head[0];
        snap_ref_d = head[1];
      end
    end

    if (ovf_now) overflow_d = 1'b1;
    if (flush)   orphan_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q    <= '0;
      mism_q     <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
      index_q    <= '0;
      snap_duv_q <= '0;
      snap_ref_q <= '0;
    end else begin
      match_q    <= match_d;
      mism_q     <= mism_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      orphan_q   <= orphan_d;
      index_q    <= index_d;
      snap_duv_q <= snap_duv_d;
      snap_ref_q <= snap_ref_d;
    end
  end

  assign match_count = match_q;
  assign mism_count  = mism_q;
  assign mismatch    = mismatch_q;
  assign overflow    = overflow_q;
  assign orphan      = orphan_q;
  assign fail        = (state_q == S_FAIL);
  assign mism_index  = index_q;
  assign mism_duv    = snap_duv_q;
  assign mism_ref    = snap_ref_q;

endmodule

// File: tb/tb_cpu_bus_lockstep_checker.sv
// tb_cpu_bus_lockstep_checker
//
// Directed bench for cpu_bus_lockstep_checker. Two instances share the same
// stimulus: u_stop (STOP_ON_MISMATCH=1) and u_cont (STOP_ON_MISMATCH=0).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after
// the following rising edge, when they reflect that edge's update.

module tb_cpu_bus_lockstep_checker;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int EW     = ADDR_W + DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              duv_valid = 1'b0;
  logic [ADDR_W-1:0] duv_addr = '0;
  logic [DATA_W-1:0] duv_data = '0;
  logic              duv_rw = 1'b0;
  logic              ref_valid = 1'b0;
  logic [ADDR_W-1:0] ref_addr = '0;
  logic [DATA_W-1:0] ref_data = '0;
  logic              ref_rw = 1'b0;

  logic [31:0]   match_s, match_c;
  logic [15:0]   mcnt_s, mcnt_c;
  logic          mism_s, mism_c;
  logic          ovf_s, ovf_c;
  logic          orph_s, orph_c;
  logic          fail_s, fail_c;
  logic [31:0]   idx_s, idx_c;
  logic [EW-1:0] sduv_s, sduv_c;
  logic [EW-1:0] sref_s, sref_c;

  int n_cmp  = 0;
  int n_mism = 0;

  always #5 clk = ~clk;

  cpu_bus_lockstep_checker #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STOP_ON_MISMATCH(1'b1)
  ) u_stop (
    .clk(clk), .rst(rst), .enable(enable),
    .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
    .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
    .match_count(match_s), .mism_count(mcnt_s), .mismatch(mism_s),
    .overflow(ovf_s), .orphan(orph_s), .fail(fail_s),
    .mism_index(idx_s), .mism_duv(sduv_s), .mism_ref(sref_s)
  );

  cpu_bus_lockstep_checker #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STOP_ON_MISMATCH(1'b0)
  ) u_cont (
    .clk(clk), .rst(rst), .enable(enable),
    .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
    .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
    .match_count(match_c), .mism_count(mcnt_c), .mismatch(mism_c),
    .overflow(ovf_c), .orphan(orph_c), .fail(fail_c),
    .mism_index(idx_c), .mism_duv(sduv_c), .mism_ref(sref_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clk with the given bus cycles on each side, then both sides idle.
  task automatic drive(input logic dv, input logic [15:0] da, input logic [7:0] dd,
                       input logic drw, input logic rv, input logic [15:0] ra,
                       input logic [7:0] rdd, input logic rrw);
    duv_valid = dv; duv_addr = da; duv_data = dd; duv_rw = drw;
    ref_valid = rv; ref_addr = ra; ref_data = rdd; ref_rw = rrw;
    tick();
    duv_valid = 1'b0;
    ref_valid = 1'b0;
  endtask

  task automatic pair(input logic [15:0] a, input logic [7:0] d, input logic rw);
    drive(1'b1, a, d, rw, 1'b1, a, d, rw);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
  endtask

  // Reset with enable and both valids high: reset must win.
  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b1;
    drive(1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 16'hFFFF, 8'hEE, 1'b1);
    rst = 1'b0;
    enable = 1'b0;
  endtask

  logic [EW-1:0] exp_duv3;
  logic [EW-1:0] exp_ref3;
  logic [15:0]   a16;
  logic [7:0]    d8;

  initial begin
    exp_duv3 = {16'hC000, 8'hA9, 1'b1};
    exp_ref3 = {16'hC000, 8'hA2, 1'b1};

    // ---- Reset state ----
    do_reset();
    chk("rst_match", match_s, 0);
    chk("rst_mcnt", mcnt_s, 0);
    chk("rst_mismatch", mism_s, 0);
    chk("rst_overflow", ovf_s, 0);
    chk("rst_orphan", orph_s, 0);
    chk("rst_fail", fail_s, 0);
    chk("rst_index", idx_s, 0);
    chk("rst_snap_duv", sduv_s, 0);
    chk("rst_snap_ref", sref_s, 0);

    // ---- 1: lockstep, 100 identical pairs ----
    enable = 1'b1;
    idle(1);
    for (int i = 0; i < 100; i++) begin
      a16 = 16'h0200 + 16'(i);
      d8  = 8'(i) ^ 8'h5A;
      pair(a16, d8, a16[0]);
      if (i == 0) chk("lat_first_push", match_s, 0);
      if (i == 1) chk("lat_first_count", match_s, 1);
    end
    idle(2);
    $display("lockstep: match_count=%0d mism_count=%0d fail=%0b", match_s, mcnt_s, fail_s);
    chk("t1_match", match_s, 100);
    chk("t1_mcnt", mcnt_s, 0);
    chk("t1_fail", fail_s, 0);
    chk("t1_match_cont", match_c, 100);

    // ---- 2: REF delayed 5 clks, 20 pairs ----
    do_reset();
    enable = 1'b1;
    idle(1);
    for (int t = 0; t < 25; t++) begin
      drive(t < 20, 16'h1000 + 16'(t), 8'(t * 3), 1'b1,
            (t >= 5) && (t < 25), 16'h1000 + 16'(t - 5), 8'((t - 5) * 3), 1'b1);
    end
    idle(3);
    $display("skew: match_count=%0d overflow=%0b", match_s, ovf_s);
    chk("t2_match", match_s, 20);
    chk("t2_overflow", ovf_s, 0);
    chk("t2_mcnt", mcnt_s, 0);

    // ---- 3: overflow, REF idle, 9 DUV pushes ----
    do_reset();
    enable = 1'b1;
    idle(1);
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 16'h2000 + 16'(k), 8'(k), 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
      if (k == 7) begin
        chk("t3_ovf_at_full", ovf_s, 0);
        chk("t3_fail_at_full", fail_s, 0);
      end
    end
    $display("overflow: overflow=%0b fail=%0b", ovf_s, fail_s);
    chk("t3_overflow", ovf_s, 1);
    chk("t3_fail", fail_s, 1);
    chk("t3_fail_cont", fail_c, 1);
    chk("t3_match", match_s, 0);

    // ---- 4/5: mismatches at pairs 3 and 7 ----
    do_reset();
    enable = 1'b1;
    idle(1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3)
        drive(1'b1, 16'hC000, 8'hA9, 1'b1, 1'b1, 16'hC000, 8'hA2, 1'b1);
      else if (i == 7)
        drive(1'b1, 16'h1234, 8'h55, 1'b0, 1'b1, 16'h1234, 8'h55, 1'b1);
      else
        pair(16'h0300 + 16'(i), 8'(i * 7), 1'b1);
      if (i == 3) chk("t4_fail_before", fail_s, 0);
      if (i == 4) chk("t4_fail_after", fail_s, 1);
    end
    idle(2);
    $display("mismatch stop: index=%0d match=%0d mism=%0d fail=%0b", idx_s, match_s, mcnt_s, fail_s);
    chk("t4_index", idx_s, 3);
    chk("t4_snap_duv", sduv_s, exp_duv3);
    chk("t4_snap_ref", sref_s, exp_ref3);
    chk("t4_fail", fail_s, 1);
    chk("t4_match", match_s, 3);
    chk("t4_mcnt", mcnt_s, 1);
    $display("mismatch cont: index=%0d match=%0d mism=%0d fail=%0b", idx_c, match_c, mcnt_c, fail_c);
    chk("t5_mcnt", mcnt_c, 2);
    chk("t5_match", match_c, 8);
    chk("t5_index", idx_c, 3);
    chk("t5_snap_duv", sduv_c, exp_duv3);
    chk("t5_snap_ref", sref_c, exp_ref3);
    chk("t5_fail", fail_c, 0);
    chk("t5_mismatch", mism_c, 1);

    // ---- 6: drain with orphan, then reset mid-RUN ----
    do_reset();
    enable = 1'b1;
    idle(1);
    pair(16'h0400, 8'h11, 1'b1);
    drive(1'b1, 16'h0401, 8'h22, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0);
    drive(1'b1, 16'h0402, 8'h33, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0);
    enable = 1'b0;
    idle(3);
    $display("drain: match_count=%0d orphan=%0b", match_s, orph_s);
    chk("t6_match", match_s, 1);
    chk("t6_orphan", orph_s, 1);
    chk("t6_mismatch", mism_s, 0);
    chk("t6_fail", fail_s, 0);
    // Idle must ignore captures, and the flush must have emptied both sides.
    drive(1'b1, 16'h0500, 8'h01, 1'b0, 1'b1, 16'h0500, 8'h02, 1'b0);
    enable = 1'b1;
    idle(1);
    pair(16'h0600, 8'h44, 1'b0);
    idle(2);
    chk("t6_after_match", match_s, 2);
    chk("t6_after_mismatch", mism_s, 0);
    // Leave one DUV entry queued, then reset while running.
    drive(1'b1, 16'h0700, 8'h55, 1'b1, 1'b0, 16'h0, 8'h0, 1'b0);
    rst = 1'b1;
    pair(16'h0701, 8'h66, 1'b1);
    rst = 1'b0;
    chk("t6_rst_match", match_s, 0);
    chk("t6_rst_orphan", orph_s, 0);
    chk("t6_rst_mcnt", mcnt_s, 0);
    chk("t6_rst_fail", fail_s, 0);
    chk("t6_rst_match_cont", match_c, 0);
    chk("t6_rst_orphan_cont", orph_c, 0);
    idle(1);
    pair(16'h0800, 8'h77, 1'b0);
    idle(2);
    chk("t6_post_rst_match", match_s, 1);
    chk("t6_post_rst_mismatch", mism_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
